// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch FSM sitting in front of a UART transmitter.
// Fabric logic may write up to one byte per clock. The FSM hands bytes to the
// transmitter one at a time and paces itself from the transmitter's active/done flags.
// Optional build macro UART_FEED_GAP_EN inserts GAP_CLKS cycles of extra idle
// line time after each frame (state S_GAP).
//
// Transmitter handshake: o_Tx_DV is a single-cycle launch pulse, and o_Tx_Byte
// is valid while it is high. A launch is issued only when the transmitter reports
// idle (i_Tx_Done=1, i_Tx_Active=0). The FSM then expects i_Tx_Done to drop
// within 4 cycles and waits for it to return high before it considers the next
// byte. If i_Tx_Done never drops, the pulse is treated as missed, and the byte
// is dropped without a retry.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef UART_FEED_GAP_EN
  ,
  parameter int GAP_CLKS = 16
`endif
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Clr_Ovf,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3
`ifdef UART_FEED_GAP_EN
    ,
    S_GAP       = 3'd4
`endif
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [1:0]          busy_cnt;
  logic                wr_acc;
  logic                launch;

  // Full/empty come straight from the registered occupancy counter.
  assign o_Full  = (o_Count == DEPTH_C);
  assign o_Empty = (o_Count == '0);
  assign wr_acc  = i_Wr_En && !o_Full;

  // Byte storage; not reset, because the contents are only read behind the count.
  always_ff @(posedge i_Clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_Wr_Byte;
    end
  end

  // Pointers, occupancy counter and sticky overflow flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, launch})
        2'b10:   o_Count <= o_Count + 1'b1;
        2'b01:   o_Count <= o_Count - 1'b1;
        default: o_Count <= o_Count;
      endcase
      // A dropped write sets the flag even when a clear arrives in the same cycle.
      if (i_Wr_En && o_Full) begin
        o_Overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
        o_Overflow <= 1'b0;
      end
    end
  end

  // FSM state register and the missed-pulse timeout counter.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      busy_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT_BUSY) begin
        busy_cnt <= busy_cnt + 1'b1;
      end else begin
        busy_cnt <= '0;
      end
    end
  end

`ifdef UART_FEED_GAP_EN
  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  logic [GAP_W-1:0] gap_cnt;

  // Counts the idle line cycles spent in S_GAP.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      gap_cnt <= '0;
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (launch) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!i_Tx_Done) begin
          state_next = S_WAIT_DONE;
        end else if (busy_cnt == 2'd3) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done && !i_Tx_Active) begin
`ifdef UART_FEED_GAP_EN
          state_next = S_GAP;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef UART_FEED_GAP_EN
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: a launch pops the FIFO head toward the transmitter.
  always_comb begin
    launch = (state == S_IDLE) && !o_Empty && i_Tx_Done && !i_Tx_Active;
  end

  // Registered launch pulse; the byte holds its value until the next launch.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= launch;
      if (launch) begin
        o_Tx_Byte <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a 4-clocks-per-bit transmitter model.
module tb_uart_tx_feeder;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;
  // Frame length counted from the DV cycle until the transmitter reports done again.
  localparam int FRAME_LEN    = FRAME_CLKS + 1;
`ifdef UART_FEED_GAP_EN
  localparam int GAP_CLKS     = 16;
  localparam int EXP_SEP      = FRAME_LEN + GAP_CLKS + 2;
`else
  localparam int EXP_SEP      = FRAME_LEN + 2;
`endif

  logic              clk;
  logic              i_Reset;
  logic              i_Wr_En;
  logic [7:0]        i_Wr_Byte;
  logic              i_Clr_Ovf;
  logic              tx_active;
  logic              tx_done;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
`ifdef UART_FEED_GAP_EN
    ,
    .GAP_CLKS(GAP_CLKS)
`endif
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Clr_Ovf  (i_Clr_Ovf),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow)
  );

  // ---------------- transmitter model ----------------
  // tx_mode: 0 = normal, 1 = ignores DV (stays idle), 2 = held busy.
  logic [1:0] tx_mode = 2'd0;
  int         tx_cnt  = 0;
  logic [9:0] tx_frame = 10'h3ff;
  logic       tx_serial;

  always @(posedge clk) begin
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end else if (o_Tx_DV === 1'b1 && tx_mode == 2'd0) begin
      tx_cnt   <= FRAME_CLKS;
      tx_frame <= {1'b1, o_Tx_Byte, 1'b0};
    end
  end

  always_comb begin
    tx_active = (tx_cnt != 0) || (tx_mode == 2'd2);
    tx_done   = !tx_active;
    tx_serial = 1'b1;
    if (tx_cnt != 0) begin
      tx_serial = tx_frame[4'((FRAME_CLKS - tx_cnt) / CLKS_PER_BIT)];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every DV pulse must carry the oldest expected byte and last one cycle.
  int   dv_count = 0;
  logic dv_prev  = 1'b0;
  always @(negedge clk) begin
    if (o_Tx_DV === 1'b1) begin
      dv_count++;
      check("dv_width", {31'd0, dv_prev}, 32'd0);
      check("dv_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("tx_byte", {24'd0, o_Tx_Byte}, {24'd0, exp_q.pop_front()});
      end
    end
    dv_prev = (o_Tx_DV === 1'b1);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic write_byte(input logic [7:0] b, input bit will_send);
    i_Wr_En   = 1'b1;
    i_Wr_Byte = b;
    if (will_send) exp_q.push_back(b);
    @(negedge clk);
    i_Wr_En   = 1'b0;
  endtask

  task automatic wait_dv(input int budget, output int n);
    n = 0;
    while (o_Tx_DV !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("dv_within_budget", {31'd0, o_Tx_DV === 1'b1}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((tx_cnt != 0 || exp_q.size() != 0 || o_Empty !== 1'b1 || o_Tx_DV === 1'b1)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'd0, n < budget}, 32'd1);
    repeat (24) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         n;
    int         base;
    logic [7:0] rx;

    i_Reset   = 1'b1;
    i_Wr_En   = 1'b0;
    i_Wr_Byte = 8'h00;
    i_Clr_Ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dv",    {31'd0, o_Tx_DV},    32'd0);
    check("rst_byte",  {24'd0, o_Tx_Byte},  32'd0);
    check("rst_count", {27'd0, o_Count},    32'd0);
    check("rst_empty", {31'd0, o_Empty},    32'd1);
    check("rst_full",  {31'd0, o_Full},     32'd0);
    check("rst_ovf",   {31'd0, o_Overflow}, 32'd0);
    i_Reset = 1'b0;
    @(negedge clk);

    // Single byte: DV in the second cycle after the write edge, serial LSB first.
    write_byte(8'hA5, 1'b1);
    check("a5_dv_early", {31'd0, o_Tx_DV}, 32'd0);
    check("a5_count1",   {27'd0, o_Count}, 32'd1);
    @(negedge clk);
    check("a5_dv",       {31'd0, o_Tx_DV}, 32'd1);
    check("a5_byte",     {24'd0, o_Tx_Byte}, 32'h0000_00a5);
    check("a5_count0",   {27'd0, o_Count}, 32'd0);
    repeat (3) @(negedge clk);
    check("a5_start_bit", {31'd0, tx_serial}, 32'd0);
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      repeat (CLKS_PER_BIT) @(negedge clk);
      rx[i] = tx_serial;
    end
    repeat (CLKS_PER_BIT) @(negedge clk);
    check("a5_stop_bit", {31'd0, tx_serial}, 32'd1);
    check("a5_serial",   {24'd0, rx}, 32'h0000_00a5);
    wait_idle(200);

    // Two queued bytes: launch-to-launch spacing.
    write_byte(8'h5A, 1'b1);
    write_byte(8'hC3, 1'b1);
    wait_dv(4, n);
    @(negedge clk);
    wait_dv(200, n);
    check("dv_separation", n + 1, EXP_SEP);
    wait_idle(200);

    // Burst of 16: the first byte drains on the second edge, so occupancy peaks at 15.
    base = dv_count;
    for (int i = 1; i <= 16; i++) begin
      write_byte(8'(i), 1'b1);
    end
    check("burst_full",  {31'd0, o_Full},     32'd0);
    check("burst_count", {27'd0, o_Count},    32'd15);
    check("burst_ovf",   {31'd0, o_Overflow}, 32'd0);
    wait_idle(16 * 80);
    check("burst_dv_pulses", dv_count - base, 16);

    // Fill with the transmitter held busy, then overflow and clear behaviour.
    tx_mode = 2'd2;
    base = dv_count;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'h80 + 8'(i), 1'b1);
    end
    check("fill_full",  {31'd0, o_Full},     32'd1);
    check("fill_count", {27'd0, o_Count},    32'd16);
    check("fill_ovf",   {31'd0, o_Overflow}, 32'd0);
    write_byte(8'hFF, 1'b0);
    check("ovf_set",    {31'd0, o_Overflow}, 32'd1);
    check("ovf_count",  {27'd0, o_Count},    32'd16);
    i_Clr_Ovf = 1'b1;
    @(negedge clk);
    i_Clr_Ovf = 1'b0;
    check("ovf_clear",  {31'd0, o_Overflow}, 32'd0);
    i_Clr_Ovf = 1'b1;
    write_byte(8'hFF, 1'b0);
    i_Clr_Ovf = 1'b0;
    check("ovf_set_wins", {31'd0, o_Overflow}, 32'd1);
    i_Clr_Ovf = 1'b1;
    @(negedge clk);
    i_Clr_Ovf = 1'b0;
    tx_mode = 2'd0;
    wait_idle(16 * 80);
    check("fill_dv_pulses", dv_count - base, 16);

    // Reset mid-frame with 5 bytes queued.
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h11 + 8'(i), 1'b1);
    end
    check("pre_rst_count", {27'd0, o_Count}, 32'd5);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    check("midrst_count", {27'd0, o_Count}, 32'd0);
    check("midrst_empty", {31'd0, o_Empty}, 32'd1);
    check("midrst_dv",    {31'd0, o_Tx_DV}, 32'd0);
    exp_q.delete();
    base = dv_count;
    n = 0;
    while (tx_cnt != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("midrst_no_dv", dv_count - base, 0);

    // Transmitter ignores DV: timeout after 4 cycles, next byte launches.
    tx_mode = 2'd1;
    base = dv_count;
    write_byte(8'h3C, 1'b1);
    write_byte(8'h7E, 1'b1);
    wait_dv(4, n);
    check("to_count1", {27'd0, o_Count}, 32'd1);
    @(negedge clk);
    wait_dv(20, n);
    check("to_separation", n + 1, 6);
    check("to_count0", {27'd0, o_Count}, 32'd0);
    tx_mode = 2'd0;
    repeat (10) @(negedge clk);
    check("to_empty", {31'd0, o_Empty}, 32'd1);
    check("to_dv_pulses", dv_count - base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
